// File: rtl/count_tracker.sv
// Sequence monitor for a 4-bit step/direction counter: infers step (1/2) and
// direction from consecutive enabled samples, locks on a stable mode and flags breaks.
module count_tracker #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [3:0] in,
  output logic       step,
  output logic       down,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LP_LOCK = 4'(LOCK_CNT);

  state_t     r_state, w_state_n;
  logic [3:0] r_prev, w_prev_n;
  logic [1:0] r_cand, w_cand_n;
  logic [3:0] r_mcnt, w_mcnt_n;
  logic       r_step, w_step_n;
  logic       r_down, w_down_n;
  logic       r_locked, w_locked_n;
  logic       r_err, w_err_n;
  logic [7:0] r_err_cnt, w_err_cnt_n;

  logic [3:0] w_d;
  logic       w_valid;
  logic [1:0] w_class;
  logic [3:0] w_run;

  // Modular delta between this enabled sample and the previous enabled one.
  assign w_d = in - r_prev;

  always_comb begin
    w_valid = 1'b1;
    w_class = 2'b00;
    case (w_d)
      4'd1:    w_class = 2'b00;
      4'd2:    w_class = 2'b10;
      4'd15:   w_class = 2'b01;
      4'd14:   w_class = 2'b11;
      default: w_valid = 1'b0;
    endcase
  end

  // Run length after this sample while acquiring.
  always_comb begin
    w_run = 4'd0;
    if (w_valid) begin
      if ((r_mcnt == 4'd0) || (w_class != r_cand)) begin
        w_run = 4'd1;
      end else begin
        w_run = r_mcnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_prev_n    = r_prev;
    w_cand_n    = r_cand;
    w_mcnt_n    = r_mcnt;
    w_step_n    = r_step;
    w_down_n    = r_down;
    w_locked_n  = r_locked;
    w_err_n     = 1'b0;
    w_err_cnt_n = r_err_cnt;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          w_prev_n  = in;
          w_state_n = ST_ACQ;
        end
        ST_ACQ: begin
          w_prev_n = in;
          w_mcnt_n = w_run;
          if (w_run == 4'd1) begin
            w_cand_n = w_class;
          end
          if (w_run == LP_LOCK) begin
            w_state_n  = ST_LOCK;
            w_locked_n = 1'b1;
            w_step_n   = w_class[1];
            w_down_n   = w_class[0];
          end
        end
        ST_LOCK: begin
          w_prev_n = in;
          if (!(w_valid && (w_class == r_cand))) begin
            w_err_n    = 1'b1;
            w_locked_n = 1'b0;
            w_state_n  = ST_ACQ;
            if (r_err_cnt != 8'hff) begin
              w_err_cnt_n = r_err_cnt + 8'd1;
            end
            // The breaking delta seeds the next acquisition run.
            if (w_valid) begin
              w_cand_n = w_class;
              w_mcnt_n = 4'd1;
            end else begin
              w_mcnt_n = 4'd0;
            end
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_prev    <= 4'd0;
      r_cand    <= 2'd0;
      r_mcnt    <= 4'd0;
      r_step    <= 1'b0;
      r_down    <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_n;
      r_prev    <= w_prev_n;
      r_cand    <= w_cand_n;
      r_mcnt    <= w_mcnt_n;
      r_step    <= w_step_n;
      r_down    <= w_down_n;
      r_locked  <= w_locked_n;
      r_err     <= w_err_n;
      r_err_cnt <= w_err_cnt_n;
    end
  end

  assign step      = r_step;
  assign down      = r_down;
  assign locked    = r_locked;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: history-based behavioural model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_count_tracker;

  localparam int LOCK_CNT = 3;

  logic       clk;
  logic       nrst;
  logic       en;
  logic [3:0] in;
  logic       step;
  logic       down;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;

  count_tracker #(.LOCK_CNT(LOCK_CNT)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .in       (in),
    .step     (step),
    .down     (down),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: classify deltas, keep the delta history of the current
  // acquisition attempt and lock when its trailing run of one class is long enough.
  function automatic int classify(input logic [3:0] d);
    case (d)
      4'd1:    return 0;
      4'd2:    return 2;
      4'd15:   return 1;
      4'd14:   return 3;
      default: return -1;
    endcase
  endfunction

  bit         m_have_prev;
  logic [3:0] m_prev;
  bit         m_locked;
  int         m_mode;
  int         m_hist[$];
  bit         m_err;
  int         m_err_cnt;
  bit         m_step;
  bit         m_down;
  logic [7:0] exp_q[$];

  function automatic int trailing_run();
    int last;
    int run;
    if (m_hist.size() == 0) return 0;
    last = m_hist[m_hist.size()-1];
    if (last < 0) return 0;
    run = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != last) break;
      run++;
    end
    return run;
  endfunction

  initial begin
    logic [3:0] d;
    int cls;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        m_have_prev = 0; m_prev = 4'd0; m_locked = 0; m_mode = 0;
        m_hist.delete(); m_err = 0; m_err_cnt = 0; m_step = 0; m_down = 0;
        exp_q.delete();
      end else begin
        m_err = 0;
        if (en) begin
          if (!m_have_prev) begin
            m_have_prev = 1;
            m_prev = in;
          end else begin
            d = in - m_prev;
            m_prev = in;
            cls = classify(d);
            if (m_locked) begin
              if (cls != m_mode) begin
                m_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
                exp_q.push_back(8'(m_err_cnt));
                m_locked = 0;
                m_hist.delete();
                m_hist.push_back(cls);
              end
            end else begin
              m_hist.push_back(cls);
              if (trailing_run() == LOCK_CNT) begin
                m_locked = 1;
                m_mode = cls;
                m_step = ((cls / 2) % 2) == 1;
                m_down = (cls % 2) == 1;
              end
            end
          end
        end
      end
    end
  end

  // Scoreboard / per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      check("locked", int'(locked), int'(m_locked));
      check("err", int'(err), int'(m_err));
      check("err_cnt", int'(err_cnt), m_err_cnt);
      if (m_locked) begin
        check("step", int'(step), int'(m_step));
        check("down", int'(down), int'(m_down));
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          check("err_unexpected", 1, 0);
        end else begin
          check("err_cnt_at_err", int'(err_cnt), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Driver tasks
  task automatic sample(input logic e, input logic [3:0] v);
    @(negedge clk);
    en = e;
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    en = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_step_down", int'({step, down}), 0);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  logic [3:0] v;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nrst = 1'b0;
    en   = 1'b0;
    in   = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_locked", int'(locked), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    nrst = 1'b1;

    // Up/1 lock
    sample(1, 4'd0);
    sample(1, 4'd1);
    sample(1, 4'd2);
    check("up1_not_yet", int'(locked), 0);
    sample(1, 4'd3);
    check("up1_locked", int'(locked), 1);
    check("up1_mode", int'({step, down}), 0);
    sample(1, 4'd4);

    // Break in lock, then relock
    sample(1, 4'd5);
    check("no_break_yet", int'(err), 0);
    sample(1, 4'd5);
    check("break_err", int'(err), 1);
    check("break_cnt", int'(err_cnt), 1);
    check("break_unlocked", int'(locked), 0);
    sample(1, 4'd6);
    check("err_one_cycle", int'(err), 0);
    sample(1, 4'd7);
    sample(1, 4'd8);
    check("relock", int'(locked), 1);
    sample(1, 4'd9);

    // Enable gating
    sample(0, 4'd14);
    check("gated_err", int'(err), 0);
    sample(1, 4'd10);
    check("gated_resume_err", int'(err), 0);
    check("gated_resume_lock", int'(locked), 1);

    // Async reset mid-lock, then invalid delta during acquisition
    async_reset();
    sample(1, 4'd0);
    sample(1, 4'd1);
    sample(1, 4'd2);
    sample(1, 4'd6);
    sample(1, 4'd7);
    sample(1, 4'd8);
    check("inv_not_locked", int'(locked), 0);
    sample(1, 4'd9);
    check("inv_locked", int'(locked), 1);
    check("inv_err_cnt", int'(err_cnt), 0);

    // Down/2 with wrap
    async_reset();
    sample(1, 4'd2);
    sample(1, 4'd0);
    sample(1, 4'd14);
    sample(1, 4'd12);
    check("dn2_locked", int'(locked), 1);
    check("dn2_mode", int'({step, down}), 3);
    sample(1, 4'd10);
    check("dn2_no_err", int'(err_cnt), 0);

    // 300 breaks, alternating up/1 and up/2 locks
    v = 4'd10;
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < 3; j++) begin
        v = v + ((k % 2 == 0) ? 4'd1 : 4'd2);
        sample(1, v);
      end
    end
    check("sat_cnt", int'(err_cnt), 255);
    check("sat_locked", int'(locked), 1);
    v = v + 4'd1;
    sample(1, v);
    check("sat_err_pulse", int'(err), 1);
    check("sat_cnt_hold", int'(err_cnt), 255);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_tracker.md
# count_tracker

Sequence monitor for the 4-bit step/direction counter. Watches the counter's `out[3:0]` bus each enabled clock and infers the counter's mode: step of 1 or 2, up or down. Once that mode is stable it reports it, and it flags any later deviation. It sits on the observing side of the counter and serves as the self-check and receiver end of the counting interface.

## Interface
- `LOCK_CNT`, default 3: consecutive identical valid deltas required to lock. Legal range 1..15.
- `clk` input 1: single clock, rising-edge.
- `nrst` input 1: asynchronous, active-low reset.
- `en` input 1: sample enable. Low means the cycle is ignored.
- `in` input 4: counter value being observed.
- `step` output 1: inferred step. 0 = by 1, 1 = by 2.
- `down` output 1: inferred direction. 0 = up, 1 = down.
- `locked` output 1: `step`/`down` are valid.
- `err` output 1: one-cycle pulse when a locked sequence is broken.
- `err_cnt` output 8: count of `err` pulses, saturating.

## Operation
- Delta: `d = (in - prev) mod 16`, with 4-bit wrap.
- Delta classification:
  - 1 → up/1
  - 2 → up/2
  - 15 → down/1
  - 14 → down/2
  - 0 and 3..13 → invalid
- Internal registers:
  - `prev[3:0]`: last sampled value.
  - `cand[1:0]`: candidate class as {step, down}.
  - `mcnt[3:0]`: run length.
- State IDLE (after reset):
  - On `en`: `prev<=in`, go to ACQ.
- State ACQ (on `en`):
  - `prev<=in` always.
  - If `d` is invalid: `mcnt<=0`.
  - Else if `mcnt==0` or class≠`cand`: `cand<=class`, `mcnt<=1`.
  - Else: `mcnt<=mcnt+1`.
  - Lock check: if the new run length equals `LOCK_CNT`, go to LOCK, set `locked<=1`, and load `step`/`down` from the class.
  - With `LOCK_CNT=1`, the first valid delta locks.
- State LOCK (on `en`):
  - `prev<=in` always.
  - If class==`cand`: stay.
  - Otherwise (including an invalid delta):
    - `err<=1` for one cycle.
    - `err_cnt<=err_cnt+1` unless it is at 255.
    - `locked<=0`, go to ACQ.
    - If `d` is valid: `cand<=class`, `mcnt<=1` (the breaking delta starts the new run). Else `mcnt<=0`.
- `step`/`down` hold their last locked value while unlocked. They are meaningful only while `locked=1`.
- A legitimate mode change of the counter is reported as an error, then the tracker relocks. This is intended.
- `en=0`:
  - No register changes except `err`, which is forced to 0.
  - `prev` is not updated, so the delta spans only enabled samples.

## Timing
- All outputs are registered and update on the rising `clk` edge that samples the deciding `in`.
- Lock latency from reset release: `LOCK_CNT+1` enabled samples. `locked` rises at the edge that takes the last one.
- `err` is high for exactly the cycle after the breaking sample edge.
  - Back-to-back breaks cannot occur, because after a break the state is ACQ.
- Reset values while `nrst=0`, applied asynchronously:
  - state=IDLE
  - `prev`, `cand`, `mcnt` = 0
  - `step`, `down`, `locked`, `err` = 0
  - `err_cnt` = 0
- Reset asserted mid-lock or mid-acquisition clears everything immediately. The prior lock is not retained.
- Wrap-around: 15→0 and 0→15 are ordinary deltas (1 and 15). 1→15 (down/2) and 14→0 (up/2) are valid.
- `err_cnt` saturates at 255. `err` still pulses at saturation.

## Test plan
- Up/1 lock (`LOCK_CNT=3`, `en=1`):
  - Stimulus: release reset, drive `in` = 0,1,2,3,4.
  - Required: `locked` rises after the edge sampling 3, with `step=0`, `down=0`. `err` stays 0.
- Down/2 with wrap:
  - Stimulus: `in` = 2,0,14,12,10.
  - Required: lock with `step=1`, `down=1`. No `err`.
- Break in lock:
  - Stimulus: after the up/1 lock, drive 5,5.
  - Required: `err` pulses once, `err_cnt=1`, `locked=0`.
  - Continue with 6,7,8,9. Required: relock up/1 after sampling 8, since the deltas are 1 (5→6), 1, 1, counting from the invalid-reset run.
- Invalid delta during ACQ:
  - Stimulus: 0,1,2,6,7,8,9.
  - Required: the delta of 4 clears the run. Lock occurs only after sampling 9. No `err`.
- Enable gating:
  - Stimulus: while locked up/1 at 4, hold `en=0` while `in` shows 9.
  - Required: no `err`. Then `en=1` with `in=5` gives no `err`.
- Async reset and saturation:
  - Drop `nrst` mid-lock. Required: all outputs are 0 before the next edge.
  - Force 300 breaks. Required: `err_cnt` stops at 255.
